// File: rtl/sprite_line_scan_if.sv
// Entry stream between the sprite line scanner and the line renderer.
//   ent_valid  scanner -> renderer  entry register holds an entry
//   ent_ready  renderer -> scanner  renderer accepts (transfer = valid & ready)
//   ent_sel    scanner -> renderer  sprite number of the entry
//   ent_x      scanner -> renderer  horizontal position (copied from attributes)
//   ent_idx    scanner -> renderer  pattern index, bottom half of 8x16 resolved
//   ent_row    scanner -> renderer  row inside the 8x8 pattern, vflip resolved
//   ent_attr   scanner -> renderer  {priority, palette[1:0], hflip}
interface sprite_line_scan_if;
  logic       ent_valid;
  logic       ent_ready;
  logic [5:0] ent_sel;
  logic [8:0] ent_x;
  logic [8:0] ent_idx;
  logic [2:0] ent_row;
  logic [3:0] ent_attr;

  modport master (
    output ent_valid,
    output ent_sel,
    output ent_x,
    output ent_idx,
    output ent_row,
    output ent_attr,
    input  ent_ready
  );

  modport slave (
    input  ent_valid,
    input  ent_sel,
    input  ent_x,
    input  ent_idx,
    input  ent_row,
    input  ent_attr,
    output ent_ready
  );
endinterface

// File: rtl/sprite_line_scan.sv
// Per-scanline sprite evaluation. On line_start the scanner walks spr_sel over
// sprites 0..63 at one sprite per cycle, reads the asynchronous attribute port
// and forwards every sprite covering line_y (up to MAX_SPR of them, in ascending
// sprite order) through a single-stage entry register to the line renderer.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   line_start, line_y    1-cycle start pulse and the line to prepare
//   spr_sel               attribute RAM read address
//   spr_*                 attributes of spr_sel, valid in the same cycle
//   ent                   entry stream (master side of sprite_line_scan_if)
//   busy                  scan or drain in progress
//   scan_done             1-cycle pulse once the line is complete and drained
//   overflow              more than MAX_SPR sprites hit the current line
module sprite_line_scan #(
  parameter int MAX_SPR = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic [7:0] line_y,
  output logic [5:0] spr_sel,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic [8:0] spr_idx,
  input  logic       spr_enable,
  input  logic       spr_priority,
  input  logic [1:0] spr_palette,
  input  logic       spr_h16,
  input  logic       spr_vflip,
  input  logic       spr_hflip,
  sprite_line_scan_if.master ent,
  output logic       busy,
  output logic       scan_done,
  output logic       overflow
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_SPR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state_reg,     state_next;
  logic [5:0] spr_sel_reg,   spr_sel_next;
  logic [7:0] line_y_reg,    line_y_next;
  logic [6:0] count_reg,     count_next;
  logic       overflow_reg,  overflow_next;
  logic       scan_done_reg, scan_done_next;
  logic       ent_valid_reg, ent_valid_next;
  logic [5:0] ent_sel_reg,   ent_sel_next;
  logic [8:0] ent_x_reg,     ent_x_next;
  logic [8:0] ent_idx_reg,   ent_idx_next;
  logic [2:0] ent_row_reg,   ent_row_next;
  logic [3:0] ent_attr_reg,  ent_attr_next;

  // Hit test for the sprite currently addressed.
  logic [7:0] dy;
  logic       hit;
  logic [3:0] row_top;
  logic [3:0] row4;
  logic [8:0] idx_res;
  logic       room;
  logic       xfer;

  // dy wraps modulo 256 so sprites starting near the bottom of the
  // coordinate space still cover the first lines.
  assign dy      = line_y_reg - spr_y;
  assign hit     = spr_enable & (spr_h16 ? (dy < 8'd16) : (dy < 8'd8));
  assign row_top = spr_h16 ? 4'd15 : 4'd7;
  assign row4    = spr_vflip ? (row_top - dy[3:0]) : dy[3:0];
  // The lower half of an 8x16 sprite is the next pattern; row4[3] is only
  // ever set for 16-line sprites.
  assign idx_res = spr_idx + {8'd0, row4[3]};
  assign room    = (count_reg < MAX_CNT);
  assign xfer    = ent_valid_reg & ent.ent_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      spr_sel_reg   <= 6'd0;
      line_y_reg    <= 8'd0;
      count_reg     <= 7'd0;
      overflow_reg  <= 1'b0;
      scan_done_reg <= 1'b0;
      ent_valid_reg <= 1'b0;
      ent_sel_reg   <= 6'd0;
      ent_x_reg     <= 9'd0;
      ent_idx_reg   <= 9'd0;
      ent_row_reg   <= 3'd0;
      ent_attr_reg  <= 4'd0;
    end else begin
      state_reg     <= state_next;
      spr_sel_reg   <= spr_sel_next;
      line_y_reg    <= line_y_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      scan_done_reg <= scan_done_next;
      ent_valid_reg <= ent_valid_next;
      ent_sel_reg   <= ent_sel_next;
      ent_x_reg     <= ent_x_next;
      ent_idx_reg   <= ent_idx_next;
      ent_row_reg   <= ent_row_next;
      ent_attr_reg  <= ent_attr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    spr_sel_next   = spr_sel_reg;
    line_y_next    = line_y_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    scan_done_next = 1'b0;
    ent_valid_next = ent_valid_reg;
    ent_sel_next   = ent_sel_reg;
    ent_x_next     = ent_x_reg;
    ent_idx_next   = ent_idx_reg;
    ent_row_next   = ent_row_reg;
    ent_attr_next  = ent_attr_reg;

    if (line_start) begin
      // A new line always wins, even mid-scan: the old line is abandoned
      // without a scan_done and any pending entry is discarded.
      state_next     = SCAN;
      spr_sel_next   = 6'd0;
      line_y_next    = line_y;
      count_next     = 7'd0;
      overflow_next  = 1'b0;
      ent_valid_next = 1'b0;
    end else begin
      if (xfer) begin
        ent_valid_next = 1'b0;
      end

      case (state_reg)
        IDLE: begin
        end

        SCAN: begin
          if (hit && !room) begin
            // One hit too many: flag it and stop scanning this line.
            overflow_next = 1'b1;
            state_next    = DRAIN;
          end else if (hit && ent_valid_reg && !ent.ent_ready) begin
            // Entry register full and not draining: hold the sprite so it
            // is not skipped.
          end else begin
            if (hit) begin
              ent_valid_next = 1'b1;
              ent_sel_next   = spr_sel_reg;
              ent_x_next     = spr_x;
              ent_idx_next   = idx_res;
              ent_row_next   = row4[2:0];
              ent_attr_next  = {spr_priority, spr_palette, spr_hflip};
              count_next     = count_reg + 7'd1;
            end
            if (spr_sel_reg == 6'd63) begin
              state_next = DRAIN;
            end else begin
              spr_sel_next = spr_sel_reg + 6'd1;
            end
          end
        end

        DRAIN: begin
          if (!ent_valid_reg) begin
            state_next     = IDLE;
            scan_done_next = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign spr_sel      = spr_sel_reg;
  assign busy         = (state_reg != IDLE);
  assign scan_done    = scan_done_reg;
  assign overflow     = overflow_reg;
  assign ent.ent_valid = ent_valid_reg;
  assign ent.ent_sel   = ent_sel_reg;
  assign ent.ent_x     = ent_x_reg;
  assign ent.ent_idx   = ent_idx_reg;
  assign ent.ent_row   = ent_row_reg;
  assign ent.ent_attr  = ent_attr_reg;

endmodule
